// File: rtl/jtriders_cabio_pkg.sv
// Shared constants for the Konami 68000 cabinet I/O block: register selects
// and the bit positions of the fields held in the two control latches.
package jtriders_cabio_pkg;

  typedef enum logic [2:0] {
    ADDR_P0   = 3'd0,
    ADDR_P1   = 3'd1,
    ADDR_P2   = 3'd2,
    ADDR_P3   = 3'd3,
    ADDR_SYS  = 3'd4,
    ADDR_STAT = 3'd5,
    ADDR_RSV6 = 3'd6,
    ADDR_RSV7 = 3'd7
  } reg_sel_e;

  // latch_lo = {cbnk[2:0], dimpol, dimmod, eep_clk, eep_cs, eep_di}
  localparam int LO_EEP_DI  = 0;
  localparam int LO_EEP_CS  = 1;
  localparam int LO_EEP_CLK = 2;
  localparam int LO_DIMMOD  = 3;
  localparam int LO_DIMPOL  = 4;
  localparam int LO_CBNK    = 5;
  localparam int CBNK_W     = 3;

  // latch_hi bits [6:3] = {dim[2:0], rmrd}
  localparam int HI_RMRD    = 3;
  localparam int HI_DIM     = 4;
  localparam int DIM_W      = 3;

endpackage

// File: rtl/jtriders_debounce.sv
// Single-channel debouncer: the output follows the raw input only after the
// raw level has disagreed with it for 2^DEBW consecutive enable ticks.
module jtriders_debounce
  import jtriders_cabio_pkg::*;
#(
  parameter int DEBW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic raw,
  output logic db
);

  logic [DEBW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;

  // A full counter means this is the 2^DEBW-th disagreeing tick.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (cen) begin
      if (raw == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == {DEBW{1'b1}}) begin
        db_d  = raw;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/jtriders_cabio.sv
// Cabinet I/O and control latches: registered input read mux, EEPROM/dim
// control latches, fake-DMA busy toggle, coin debounce and frame watchdog.
module jtriders_cabio
  import jtriders_cabio_pkg::*;
#(
  parameter int PLAYERS     = 4,
  parameter int JW          = 7,
  parameter int COINW       = 4,
  parameter int DEBW        = 3,
  parameter int WDOG_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_cen,
  input  logic                  cab_cs,
  input  logic [2:0]            addr,
  input  logic                  iowr_lo,
  input  logic                  iowr_hi,
  input  logic                  wdog_cs,
  input  logic [7:0]            din,
  input  logic [PLAYERS*JW-1:0] joy,
  input  logic [PLAYERS-1:0]    start,
  input  logic [COINW-1:0]      coin,
  input  logic [COINW-1:0]      service,
  input  logic                  dip_test,
  input  logic                  lvbl,
  input  logic                  irq_st,
  input  logic                  eep_rdy,
  input  logic                  eep_do,
  output logic [7:0]            dout,
  output logic [7:0]            latch_lo,
  output logic [7:0]            latch_hi,
  output logic                  busy,
  output logic                  wdog_rst
);

  localparam int PN  = (PLAYERS < 4) ? PLAYERS : 4;
  localparam int JE  = (JW < 7) ? JW : 7;
  localparam int CE  = (COINW < 4) ? COINW : 4;
  localparam int WDW = (WDOG_FRAMES > 0) ? $clog2(WDOG_FRAMES + 1) : 1;

  logic [COINW-1:0] coin_db, service_db;

  genvar gi;
  generate
    for (gi = 0; gi < COINW; gi++) begin : g_deb
      jtriders_debounce #(.DEBW(DEBW)) u_coin (
        .clk (clk),
        .rst (rst),
        .cen (cpu_cen),
        .raw (coin[gi]),
        .db  (coin_db[gi])
      );
      jtriders_debounce #(.DEBW(DEBW)) u_service (
        .clk (clk),
        .rst (rst),
        .cen (cpu_cen),
        .raw (service[gi]),
        .db  (service_db[gi])
      );
    end
  endgenerate

  logic [7:0]     dout_q, dout_d;
  logic [7:0]     latch_lo_q, latch_lo_d;
  logic [7:0]     latch_hi_q, latch_hi_d;
  logic           busy_q, busy_d;
  logic           cs_l_q, cs_l_d;
  logic           lvbl_l_q, lvbl_l_d;
  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           wdog_rst_q, wdog_rst_d;
  logic [7:0]     rd_data, sys_byte;
  logic           lvbl_fall;

  // Unpopulated player ports, missing joystick bits and missing coin
  // channels all read back as released (1).
  always_comb begin
    sys_byte = 8'hFF;
    for (int i = 0; i < CE; i++) begin
      sys_byte[i]     = coin_db[i];
      sys_byte[4 + i] = service_db[i];
    end
    rd_data = 8'hFF;
    case (addr)
      ADDR_SYS:  rd_data = sys_byte;
      ADDR_STAT: rd_data = {dip_test, 2'b11, irq_st, lvbl, busy_q, eep_rdy, eep_do};
      default: begin
        for (int p = 0; p < PN; p++) begin
          if (addr == 3'(p)) begin
            rd_data[7] = start[p];
            for (int b = 0; b < JE; b++) rd_data[b] = joy[p*JW + b];
          end
        end
      end
    endcase
  end

  assign lvbl_fall = lvbl_l_q & ~lvbl;

  always_comb begin
    dout_d     = cab_cs  ? rd_data : dout_q;
    latch_lo_d = iowr_lo ? din     : latch_lo_q;
    latch_hi_d = iowr_hi ? din     : latch_hi_q;
    cs_l_d     = cs_l_q;
    busy_d     = busy_q;
    // Busy only flips once the CPU has stopped polling for two enables.
    if (cpu_cen) begin
      cs_l_d = cab_cs;
      if (!cab_cs && !cs_l_q) busy_d = ~busy_q;
    end
    lvbl_l_d   = lvbl;
    wdog_cnt_d = wdog_cnt_q;
    wdog_rst_d = 1'b0;
    if (WDOG_FRAMES == 0) begin
      wdog_cnt_d = '0;
    end else if (wdog_cs) begin
      wdog_cnt_d = '0;
    end else if (lvbl_fall) begin
      if (wdog_cnt_q == WDW'(WDOG_FRAMES - 1)) begin
        wdog_rst_d = 1'b1;
        wdog_cnt_d = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WDW'(1);
      end
    end
  end

  // cs_l starts high so the CPU is treated as polling right after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q     <= 8'hFF;
      latch_lo_q <= 8'h00;
      latch_hi_q <= 8'h00;
      busy_q     <= 1'b0;
      cs_l_q     <= 1'b1;
      lvbl_l_q   <= 1'b0;
      wdog_cnt_q <= '0;
      wdog_rst_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      latch_lo_q <= latch_lo_d;
      latch_hi_q <= latch_hi_d;
      busy_q     <= busy_d;
      cs_l_q     <= cs_l_d;
      lvbl_l_q   <= lvbl_l_d;
      wdog_cnt_q <= wdog_cnt_d;
      wdog_rst_q <= wdog_rst_d;
    end
  end

  assign dout     = dout_q;
  assign latch_lo = latch_lo_q;
  assign latch_hi = latch_hi_q;
  assign busy     = busy_q;
  assign wdog_rst = wdog_rst_q;

endmodule

// File: tb/tb_jtriders_cabio.sv
// Directed bench for jtriders_cabio with two players and a 4-frame watchdog.
module tb_jtriders_cabio;
  import jtriders_cabio_pkg::*;

  localparam int PLAYERS     = 2;
  localparam int JW          = 7;
  localparam int COINW       = 4;
  localparam int DEBW        = 3;
  localparam int WDOG_FRAMES = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cpu_cen, cab_cs, iowr_lo, iowr_hi, wdog_cs;
  logic [2:0]            addr;
  logic [7:0]            din;
  logic [PLAYERS*JW-1:0] joy;
  logic [PLAYERS-1:0]    start;
  logic [COINW-1:0]      coin, service;
  logic                  dip_test, lvbl, irq_st, eep_rdy, eep_do;
  logic [7:0]            dout, latch_lo, latch_hi;
  logic                  busy, wdog_rst;

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  logic busy_m, cs_l_m, b0;

  jtriders_cabio #(
    .PLAYERS(PLAYERS), .JW(JW), .COINW(COINW), .DEBW(DEBW), .WDOG_FRAMES(WDOG_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cab_cs(cab_cs), .addr(addr),
    .iowr_lo(iowr_lo), .iowr_hi(iowr_hi), .wdog_cs(wdog_cs), .din(din),
    .joy(joy), .start(start), .coin(coin), .service(service),
    .dip_test(dip_test), .lvbl(lvbl), .irq_st(irq_st), .eep_rdy(eep_rdy),
    .eep_do(eep_do), .dout(dout), .latch_lo(latch_lo), .latch_hi(latch_hi),
    .busy(busy), .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  // One clock with optional cpu_cen; busy_m/cs_l_m track the expected toggle.
  task automatic apply_stimulus(input logic cen);
    cpu_cen = cen;
    @(posedge clk);
    if (!rst) begin
      busy_m = 1'b0;
      cs_l_m = 1'b1;
    end else if (cen) begin
      if (!cab_cs && !cs_l_m) busy_m = ~busy_m;
      cs_l_m = cab_cs;
    end
    #1;
    cpu_cen = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lvbl_edge(input logic kick);
    lvbl = 1'b1;
    apply_stimulus(1'b0);
    lvbl    = 1'b0;
    wdog_cs = kick;
    apply_stimulus(1'b0);
    wdog_cs = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cpu_cen = 1'b0; cab_cs = 1'b0; addr = 3'd0;
    iowr_lo = 1'b0; iowr_hi = 1'b0; wdog_cs = 1'b0; din = 8'h00;
    joy = {7'h33, 7'h5A}; start = 2'b10;
    coin = 4'hF; service = 4'hF;
    dip_test = 1'b0; lvbl = 1'b1; irq_st = 1'b0; eep_rdy = 1'b1; eep_do = 1'b0;
    busy_m = 1'b0; cs_l_m = 1'b1;

    for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
    check_output("rst_dout", dout, 8'hFF);
    check_output("rst_latch_lo", latch_lo, 8'h00);
    check_output("rst_latch_hi", latch_hi, 8'h00);
    check_output("rst_busy", {7'd0, busy}, 8'h00);
    check_output("rst_wdog", {7'd0, wdog_rst}, 8'h00);

    rst = 1'b1;
    cab_cs = 1'b1; addr = ADDR_STAT;
    apply_stimulus(1'b0);
    check_output("stat_after_reset", dout, 8'h6A);

    addr = ADDR_P0; apply_stimulus(1'b0);
    check_output("p0_read", dout, 8'h5A);
    addr = ADDR_P1; apply_stimulus(1'b0);
    check_output("p1_read", dout, 8'hB3);
    addr = ADDR_P2; apply_stimulus(1'b0);
    check_output("p2_absent", dout, 8'hFF);
    addr = ADDR_P3; apply_stimulus(1'b0);
    check_output("p3_absent", dout, 8'hFF);
    addr = ADDR_RSV6; apply_stimulus(1'b0);
    check_output("addr6", dout, 8'hFF);
    addr = ADDR_P0; apply_stimulus(1'b0);
    cab_cs = 1'b0; addr = ADDR_P1; apply_stimulus(1'b0);
    check_output("dout_hold", dout, 8'h5A);

    cab_cs = 1'b1; addr = ADDR_SYS;
    apply_stimulus(1'b1);
    check_output("sys_idle", dout, 8'hFF);
    coin = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1);
      check_output("coin_glitch", dout, 8'hFF);
    end
    coin = 4'hF;
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    check_output("coin_glitch_gone", dout, 8'hFF);
    coin = 4'b1110;
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("coin_7_ticks", dout, 8'hFF);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("coin_8_ticks", dout, 8'hFE);
    service = 4'b1011;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("service2", dout, 8'hBE);

    din = 8'h5A; iowr_lo = 1'b1; iowr_hi = 1'b1;
    apply_stimulus(1'b0);
    iowr_lo = 1'b0; iowr_hi = 1'b0;
    check_output("both_lo", latch_lo, 8'h5A);
    check_output("both_hi", latch_hi, 8'h5A);
    din = 8'hA5; iowr_lo = 1'b1; apply_stimulus(1'b0); iowr_lo = 1'b0;
    din = 8'h3C; iowr_hi = 1'b1; apply_stimulus(1'b0); iowr_hi = 1'b0;
    din = 8'h00; apply_stimulus(1'b0);
    check_output("latch_lo_a5", latch_lo, 8'hA5);
    check_output("latch_hi_3c", latch_hi, 8'h3C);
    check_output("eep_cs_field", {7'd0, latch_lo[LO_EEP_CS]}, 8'h00);
    check_output("rmrd_field", {7'd0, latch_hi[HI_RMRD]}, 8'h01);

    cab_cs = 1'b1; apply_stimulus(1'b1);
    b0 = busy_m;
    cab_cs = 1'b0;
    apply_stimulus(1'b1);
    check_output("busy_first_cen", {7'd0, busy}, {7'd0, b0});
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1);
      check_output("busy_toggle", {7'd0, busy}, {7'd0, busy_m});
    end
    check_output("busy_after_6", {7'd0, busy}, {7'd0, ~b0});
    cab_cs = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
    check_output("busy_polled", {7'd0, busy}, {7'd0, ~b0});

    dip_test = 1'b1; irq_st = 1'b1; eep_rdy = 1'b0; eep_do = 1'b1;
    addr = ADDR_STAT; apply_stimulus(1'b0);
    check_output("stat_busy", dout, {5'b11111, ~b0, 1'b0, 1'b1});

    for (int e = 1; e <= 4; e++) begin
      lvbl_edge(1'b0);
      check_output("wdog_edge", {7'd0, wdog_rst}, (e == 4) ? 8'h01 : 8'h00);
    end
    apply_stimulus(1'b0);
    check_output("wdog_one_clk", {7'd0, wdog_rst}, 8'h00);
    for (int e = 1; e <= 7; e++) begin
      lvbl_edge(e == 3);
      check_output("wdog_kick", {7'd0, wdog_rst}, (e == 7) ? 8'h01 : 8'h00);
    end

    for (int e = 0; e < 3; e++) lvbl_edge(1'b0);
    coin = 4'b1101; service = 4'hF; addr = ADDR_SYS;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1);
    rst = 1'b0; apply_stimulus(1'b0);
    check_output("midrst_dout", dout, 8'hFF);
    check_output("midrst_latch_lo", latch_lo, 8'h00);
    check_output("midrst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b1;
    apply_stimulus(1'b1); apply_stimulus(1'b1); apply_stimulus(1'b0);
    check_output("midrst_deb_cleared", dout, 8'hFF);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("midrst_deb_full", dout, 8'hFD);
    for (int e = 1; e <= 4; e++) begin
      lvbl_edge(1'b0);
      check_output("midrst_wdog", {7'd0, wdog_rst}, (e == 4) ? 8'h01 : 8'h00);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
